lif_core_scheduler: RTL
=======================

// Module: lif_core_scheduler
// PURPOSE
//   Time-multiplexes one leaky-integrate-and-fire update datapath across N_NEURONS neurons.
//   Between timesteps it accumulates input currents per neuron.
//   On each step pulse it sweeps every neuron in index order and emits spike events over a
//   valid/ready stream. It also holds the shared threshold/beta configuration.
//   It sits between the input encoder (upstream) and the spike router (downstream).
// PARAMETERS
//   N_NEURONS  8  number of neurons served; must be >= 2
//   VW         8  membrane potential / accumulator width, unsigned
//   IW         4  input current sample width, unsigned
//   BSHIFT     4  beta fraction bits: leak factor = beta / 2**BSHIFT
// PORTS
//   clk        in   1                    clock
//   rst_n      in   1                    reset, synchronous, active-low
//   step       in   1                    start-timestep pulse
//   in_valid   in   1                    input current sample valid
//   in_ready   out  1                    sample accepted when in_valid & in_ready
//   in_idx     in   $clog2(N_NEURONS)    target neuron of sample
//   in_value   in   IW                   current to add to neuron accumulator
//   cfg_we     in   1                    config write strobe
//   cfg_addr   in   1                    0 = threshold, 1 = beta
//   cfg_data   in   VW                   config write data
//   spk_valid  out  1                    spike event valid
//   spk_ready  in   1                    downstream accepts spike event
//   spk_idx    out  $clog2(N_NEURONS)    index of spiking neuron
//   busy       out  1                    high in any state other than IDLE
//   step_done  out  1                    one-cycle pulse at end of sweep
// BEHAVIOUR
//   Reset values
//   - All v[i] = 0 and all acc[i] = 0; threshold = 128; beta = 10.
//   - FSM = IDLE; spk_valid = 0; step_done = 0; busy = 0; in_ready = 1; spk_idx = 0.
//   States
//   - IDLE -> UPDATE when step = 1; neuron pointer i = 0.
//   - UPDATE: one neuron per cycle.
//     - lk = (v[i] * beta) >> BSHIFT, computed at 2*VW width.
//     - nv = sat_VW(lk + acc[i]); acc[i] <= 0.
//     - If nv >= threshold: v[i] <= 0, go to EMIT.
//     - Else: v[i] <= nv; i++. At i = N_NEURONS-1 go to DONE instead.
//   - EMIT: spk_valid = 1 and spk_idx = i, held stable until spk_ready.
//     - On handshake: i++ and return to UPDATE, or go to DONE if i was the last neuron.
//   - DONE: step_done = 1 for one cycle, then IDLE.
//   Saturation and wrap
//   - sat_VW clamps to 2**VW-1; no wrap-around anywhere.
//   - beta > 2**BSHIFT is legal (growth); the result still saturates.
//   Input path
//   - in_ready = 1 only in IDLE.
//   - Accepted sample: acc[in_idx] <= sat_VW(acc[in_idx] + in_value).
//   - in_idx >= N_NEURONS: sample is consumed and dropped.
//   Config path
//   - cfg_we honoured only in IDLE; ignored while busy.
//   - New values apply to the next sweep.
//   Simultaneous events
//   - step together with an accepted in_valid in IDLE: the sample is accumulated before
//     the sweep starts, so neuron 0 (and the rest) see it this step.
//   - step while busy is ignored (not queued).
//   - cfg_we together with step in IDLE: the write takes effect, and the sweep uses the
//     new value.
//   Latency
//   - step to step_done = N_NEURONS + (#spikes) + (total spk_ready stall cycles) + 1 cycles.
//   Special thresholds
//   - threshold = 0: every neuron spikes every step.
//   - threshold = 2**VW-1: a neuron spikes only when saturated.
//   - Reset mid-sweep returns all state to reset values next cycle; a pending spike is dropped.
// TESTING
//   1 Reset, then step with no input, spk_ready = 1
//     -> no spk_valid; step_done exactly 9 cycles after step (N = 8).
//   2 In IDLE: in_value = 15 to neuron 3, nine times; threshold = 128; step
//     -> acc = 135 >= 128, so exactly one spike with spk_idx = 3; v[3] = 0 afterwards.
//   3 beta = 8 (0.5), v[0] = 100, no input, step
//     -> v[0] = 50; on the next step v[0] = 25; no spikes.
//   4 threshold = 0, spk_ready low for 5 cycles per event
//     -> spikes 0..7 in order, each held stable; step_done at 8 + 8 + 40 + 1 = 57 cycles.
//   5 While busy: pulse step, cfg_we, and in_valid
//     -> in_ready = 0, threshold unchanged, no second sweep.
//   6 Assert rst_n = 0 during EMIT
//     -> next cycle spk_valid = 0, busy = 0, all potentials and accumulators = 0.

Source files
------------

// File: rtl/lif_core_scheduler.sv
// lif_core_scheduler: one shared leaky-integrate-and-fire update datapath,
// time-multiplexed over N_NEURONS neurons. Input currents accumulate per neuron
// while idle; a step pulse sweeps all neurons in index order and streams spike
// events out over a valid/ready handshake.
module lif_core_scheduler #(
   parameter int N_NEURONS = 8,
   parameter int VW        = 8,
   parameter int IW        = 4,
   parameter int BSHIFT    = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         step,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [$clog2(N_NEURONS)-1:0] in_idx,
   input  logic [IW-1:0]                in_value,
   input  logic                         cfg_we,
   input  logic                         cfg_addr,
   input  logic [VW-1:0]                cfg_data,
   output logic                         spk_valid,
   input  logic                         spk_ready,
   output logic [$clog2(N_NEURONS)-1:0] spk_idx,
   output logic                         busy,
   output logic                         step_done
);

   localparam int                IDXW = $clog2(N_NEURONS);
   localparam logic [IDXW-1:0]   LAST = IDXW'(N_NEURONS - 1);
   localparam logic [IDXW:0]     NUM  = (IDXW + 1)'(N_NEURONS);

   typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} state_t;

   state_t            state, state_nx;
   logic [IDXW-1:0]   ptr;
   logic [VW-1:0]     threshold;
   logic [VW-1:0]     beta;
   logic [VW-1:0]     v   [N_NEURONS];
   logic [VW-1:0]     acc [N_NEURONS];

   logic [2*VW-1:0]   prod;
   logic [2*VW:0]     upd_sum;
   logic [2*VW:0]     in_sum;
   logic [VW-1:0]     nv;
   logic              fire;
   logic              last;
   logic              in_ok;

   // Clamp a wide unsigned sum to the VW-bit range; nothing ever wraps.
   function automatic logic [VW-1:0] sat_vw(input logic [2*VW:0] x);
      if (|x[2*VW:VW]) return '1;
      return x[VW-1:0];
   endfunction

   // Leak-and-integrate for the neuron under the pointer, plus the input-path sum.
   always_comb begin
      prod    = (2*VW)'(v[ptr]) * (2*VW)'(beta);
      upd_sum = (2*VW+1)'(prod >> BSHIFT) + (2*VW+1)'(acc[ptr]);
      nv      = sat_vw(upd_sum);
      fire    = (nv >= threshold);
      last    = (ptr == LAST);
      in_sum  = (2*VW+1)'(acc[in_idx]) + (2*VW+1)'(in_value);
      in_ok   = in_valid && (state == IDLE) && ({1'b0, in_idx} < NUM);
   end

   // Sweep sequencer state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state selection; a step that arrives while busy is simply not seen.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (step) state_nx = UPDATE;
         UPDATE:  if (fire) state_nx = EMIT;
                  else if (last) state_nx = DONE;
         EMIT:    if (spk_ready) state_nx = last ? DONE : UPDATE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign spk_valid = (state == EMIT);
   assign step_done = (state == DONE);
   assign spk_idx   = ptr;

   // Neuron state, accumulators, configuration and sweep pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         threshold <= VW'(128);
         beta      <= VW'(10);
         for (int k = 0; k < N_NEURONS; k++) begin
            v[k]   <= '0;
            acc[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               // Config and samples land on the same edge as step, so the sweep sees them.
               if (cfg_we) begin
                  if (cfg_addr) beta      <= cfg_data;
                  else          threshold <= cfg_data;
               end
               if (in_ok) acc[in_idx] <= sat_vw(in_sum);
               if (step)  ptr <= '0;
            end
            UPDATE: begin
               acc[ptr] <= '0;
               if (fire) begin
                  v[ptr] <= '0;
               end else begin
                  v[ptr] <= nv;
                  if (!last) ptr <= ptr + IDXW'(1);
               end
            end
            EMIT: begin
               // Pointer holds so spk_idx stays stable while stalled.
               if (spk_ready && !last) ptr <= ptr + IDXW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
